// File: rtl/dpi_mem_port.sv
// Purpose: single-outstanding request/response port in front of a word-addressed memory.
// Latency: response valid 1+LATENCY edges after the accept edge.
// Backpressure: one request at a time; the response is held stable until resp_ready.
//
// Each 32-bit pmem_read/pmem_write call is a one-cycle mem_rd_en/mem_wr_en strobe
// on the internal store. The strobes are active only on the access edge.
module dpi_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1,
    parameter int MEM_AW     = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [31:0]             txn_count
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LG        = $clog2(NBYTES);
    localparam int NW        = DATA_WIDTH / 32;
    localparam int MEM_WORDS = 1 << MEM_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           txn_q, txn_d;

    logic [31:0]           mem [MEM_WORDS];
    logic [MEM_AW-1:0]     widx [NW];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  access;
    logic                  aligned;
    logic [NW-1:0]         mem_rd_en;
    logic [NW-1:0]         mem_wr_en;

    // Word indices for the latched address (upper word at addr+4) and the pre-write read data.
    always_comb begin
        rd_data = '0;
        for (int w = 0; w < NW; w++) begin
            widx[w]              = MEM_AW'((addr_q >> 2) + 32'(w));
            rd_data[32*w +: 32]  = mem[widx[w]];
        end
    end

    // Access strobes: one edge only, never for misaligned requests or while in reset.
    always_comb begin
        access    = (state_q == WAIT) && (cnt_q == 4'd0);
        aligned   = (addr_q[LG-1:0] == '0);
        mem_rd_en = '0;
        mem_wr_en = '0;
        for (int w = 0; w < NW; w++) begin
            mem_rd_en[w] = reset && access && aligned;
            mem_wr_en[w] = reset && access && aligned && we_q && (|wmask_q[4*w +: 4]);
        end
    end

    // Byte-masked write; the read above sees the old contents on the same edge.
    always_ff @(posedge clock) begin
        for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wr_en[w] && wmask_q[4*w + b]) begin
                    mem[widx[w]][8*b +: 8] <= wdata_q[32*w + 8*b +: 8];
                end
            end
        end
    end

    // Next-state and datapath: accept in IDLE, count down in WAIT, hold response in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        txn_d   = txn_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = aligned ? rd_data : '0;
                    err_d   = !aligned;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    txn_d   = txn_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    assign req_ready  = reset && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_dpi_mem_port.sv
// Purpose: directed bench for dpi_mem_port in three configurations (32/L1, 64/L0, 32/L3).
// Latency: n/a (bench).
// Backpressure: exercises resp_ready stalls and reset during an in-flight access.
module tb_dpi_mem_port;

    logic        clk;
    logic        rst_n;
    logic        c_rst_n;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        resp_ready;
    logic        a_vld, b_vld, c_vld;

    logic        a_rdy, a_rv, a_err;
    logic [31:0] a_rdata, a_cnt;
    logic        b_rdy, b_rv, b_err;
    logic [63:0] b_rdata;
    logic [31:0] b_cnt;
    logic        c_rdy, c_rv, c_err;
    logic [31:0] c_rdata, c_cnt;

    int          sel;
    logic        m_rdy, m_rv, m_err;
    logic [63:0] m_rdata;
    logic [31:0] m_cnt;

    int          rd_calls [3];
    int          wr_calls [3];
    int          call_edges [3];
    int          exp_cnt [3];
    int          errors;
    int          checks;

    dpi_mem_port #(.DATA_WIDTH(32), .LATENCY(1)) u_a (
        .clock(clk), .reset(rst_n), .req_valid(a_vld), .req_ready(a_rdy),
        .req_we(we), .req_addr(addr), .req_wdata(wdata[31:0]), .req_wmask(wmask[3:0]),
        .resp_valid(a_rv), .resp_ready(resp_ready), .resp_rdata(a_rdata),
        .resp_err(a_err), .txn_count(a_cnt)
    );

    dpi_mem_port #(.DATA_WIDTH(64), .LATENCY(0)) u_b (
        .clock(clk), .reset(rst_n), .req_valid(b_vld), .req_ready(b_rdy),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_wmask(wmask),
        .resp_valid(b_rv), .resp_ready(resp_ready), .resp_rdata(b_rdata),
        .resp_err(b_err), .txn_count(b_cnt)
    );

    dpi_mem_port #(.DATA_WIDTH(32), .LATENCY(3)) u_c (
        .clock(clk), .reset(c_rst_n), .req_valid(c_vld), .req_ready(c_rdy),
        .req_we(we), .req_addr(addr), .req_wdata(wdata[31:0]), .req_wmask(wmask[3:0]),
        .resp_valid(c_rv), .resp_ready(resp_ready), .resp_rdata(c_rdata),
        .resp_err(c_err), .txn_count(c_cnt)
    );

    always #5 clk = ~clk;

    // Route the selected instance's outputs to common names.
    always_comb begin
        m_rdy   = a_rdy;
        m_rv    = a_rv;
        m_err   = a_err;
        m_rdata = {32'd0, a_rdata};
        m_cnt   = a_cnt;
        case (sel)
            1: begin
                m_rdy = b_rdy; m_rv = b_rv; m_err = b_err; m_rdata = b_rdata; m_cnt = b_cnt;
            end
            2: begin
                m_rdy = c_rdy; m_rv = c_rv; m_err = c_err; m_rdata = {32'd0, c_rdata}; m_cnt = c_cnt;
            end
            default: ;
        endcase
    end

    // Memory call tally: strobes are stable between edges, so sample mid-cycle.
    always @(negedge clk) begin
        rd_calls[0] += $countones(u_a.mem_rd_en);
        wr_calls[0] += $countones(u_a.mem_wr_en);
        if ((|u_a.mem_rd_en) || (|u_a.mem_wr_en)) call_edges[0] += 1;
        rd_calls[1] += $countones(u_b.mem_rd_en);
        wr_calls[1] += $countones(u_b.mem_wr_en);
        if ((|u_b.mem_rd_en) || (|u_b.mem_wr_en)) call_edges[1] += 1;
        rd_calls[2] += $countones(u_c.mem_rd_en);
        wr_calls[2] += $countones(u_c.mem_wr_en);
        if ((|u_c.mem_rd_en) || (|u_c.mem_wr_en)) call_edges[2] += 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_vld(input int s, input logic v);
        case (s)
            0:       a_vld = v;
            1:       b_vld = v;
            default: c_vld = v;
        endcase
    endtask

    // One full transaction on instance s, with optional response stall.
    task automatic run(input string tag, input int s, input logic w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] m, input int stall,
                       input logic chk_rd, input logic [63:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_rdc, input int exp_wrc);
        int r0, w0, e0, n, lat;
        sel        = s;
        resp_ready = (stall == 0);
        r0 = rd_calls[s];
        w0 = wr_calls[s];
        e0 = call_edges[s];
        @(negedge clk);
        we = w; addr = a; wdata = d; wmask = m;
        set_vld(s, 1'b1);
        n = 0;
        while (!m_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 64'(n < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        set_vld(s, 1'b0);
        we = ~w; addr = a ^ 32'h7; wdata = ~d; wmask = ~m;
        lat = 0;
        while (!m_rv && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (chk_rd) check({tag, " rdata"}, m_rdata, exp_rd);
        check({tag, " err"}, 64'(m_err), 64'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " hold_vld"}, 64'(m_rv), 64'd1);
            check({tag, " hold_rdata"}, m_rdata, exp_rd);
            check({tag, " hold_rdy"}, 64'(m_rdy), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        exp_cnt[s]++;
        check({tag, " vld_after"}, 64'(m_rv), 64'd0);
        check({tag, " rdy_after"}, 64'(m_rdy), 64'd1);
        check({tag, " txn_count"}, 64'(m_cnt), 64'(exp_cnt[s]));
        check({tag, " rd_calls"}, 64'(rd_calls[s] - r0), 64'(exp_rdc));
        check({tag, " wr_calls"}, 64'(wr_calls[s] - w0), 64'(exp_wrc));
        check({tag, " call_edges"}, 64'(call_edges[s] - e0), 64'((exp_rdc > 0) ? 1 : 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        clk = 1'b0; rst_n = 1'b1; c_rst_n = 1'b1;
        we = 1'b0; addr = '0; wdata = '0; wmask = '0; resp_ready = 1'b1;
        a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
        sel = 0; errors = 0; checks = 0;
        for (int i = 0; i < 3; i++) begin
            rd_calls[i] = 0; wr_calls[i] = 0; call_edges[i] = 0; exp_cnt[i] = 0;
        end

        #2;
        rst_n = 1'b0; c_rst_n = 1'b0;
        @(negedge clk);
        check("rst a_rdy", 64'(a_rdy), 64'd0);
        check("rst a_rv", 64'(a_rv), 64'd0);
        check("rst a_rdata", 64'(a_rdata), 64'd0);
        check("rst a_err", 64'(a_err), 64'd0);
        check("rst a_cnt", 64'(a_cnt), 64'd0);
        check("rst b_rdy", 64'(b_rdy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; c_rst_n = 1'b1;
        #1;
        check("rel a_rdy", 64'(a_rdy), 64'd1);

        // 32-bit, LATENCY=1: response two edges after accept.
        run("a_wr0",   0, 1'b1, 32'h8000_0000, 64'h1234_5678, 8'hF, 0, 1'b0, 64'h0, 1'b0, 2, 1, 1);
        run("a_rd",    0, 1'b0, 32'h8000_0000, 64'h0,         8'h0, 0, 1'b1, 64'h1234_5678, 1'b0, 2, 1, 0);
        run("a_pre",   0, 1'b1, 32'h8000_0004, 64'h1122_3344, 8'hF, 0, 1'b0, 64'h0, 1'b0, 2, 1, 1);
        run("a_part",  0, 1'b1, 32'h8000_0004, 64'hAABB_CCDD, 8'h3, 0, 1'b1, 64'h1122_3344, 1'b0, 2, 1, 1);
        run("a_rdbk",  0, 1'b0, 32'h8000_0004, 64'h0,         8'h0, 0, 1'b1, 64'h1122_CCDD, 1'b0, 2, 1, 0);
        run("a_zmask", 0, 1'b1, 32'h8000_0004, 64'hFFFF_FFFF, 8'h0, 0, 1'b1, 64'h1122_CCDD, 1'b0, 2, 1, 0);
        run("a_rdbk2", 0, 1'b0, 32'h8000_0004, 64'h0,         8'h0, 0, 1'b1, 64'h1122_CCDD, 1'b0, 2, 1, 0);
        run("a_mis",   0, 1'b0, 32'h8000_0002, 64'h0,         8'h0, 0, 1'b1, 64'h0, 1'b1, 2, 0, 0);
        run("a_miswr", 0, 1'b1, 32'h8000_0001, 64'hFFFF_FFFF, 8'hF, 0, 1'b1, 64'h0, 1'b1, 2, 0, 0);
        run("a_stall", 0, 1'b0, 32'h8000_0000, 64'h0,         8'h0, 5, 1'b1, 64'h1234_5678, 1'b0, 2, 1, 0);

        // 64-bit, LATENCY=0: two word calls on one edge, response one edge after accept.
        run("b_pre",   1, 1'b1, 32'h8000_0008, 64'hDEAD_BEEF_CAFE_BABE, 8'hFF, 0, 1'b0, 64'h0, 1'b0, 1, 2, 2);
        run("b_rd",    1, 1'b0, 32'h8000_0008, 64'h0, 8'h00, 0, 1'b1, 64'hDEAD_BEEF_CAFE_BABE, 1'b0, 1, 2, 0);
        run("b_hi",    1, 1'b1, 32'h8000_0008, 64'h0102_0304_0506_0708, 8'hF0, 0, 1'b1,
            64'hDEAD_BEEF_CAFE_BABE, 1'b0, 1, 2, 1);
        run("b_rd2",   1, 1'b0, 32'h8000_0008, 64'h0, 8'h00, 0, 1'b1, 64'h0102_0304_CAFE_BABE, 1'b0, 1, 2, 0);
        run("b_mis",   1, 1'b0, 32'h8000_0004, 64'h0, 8'h00, 0, 1'b1, 64'h0, 1'b1, 1, 0, 0);

        // 32-bit, LATENCY=3: two completed transactions, then reset mid-WAIT.
        run("c_pre",   2, 1'b1, 32'h8000_0010, 64'hCAFE_F00D, 8'hF, 0, 1'b0, 64'h0, 1'b0, 4, 1, 1);
        run("c_rd",    2, 1'b0, 32'h8000_0010, 64'h0,         8'h0, 0, 1'b1, 64'hCAFE_F00D, 1'b0, 4, 1, 0);
        sel = 2;
        r0  = rd_calls[2] + wr_calls[2];
        @(negedge clk);
        we = 1'b0; addr = 32'h8000_0010; c_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_vld = 1'b0;
        check("c_wait rdy", 64'(c_rdy), 64'd0);
        @(negedge clk);
        c_rst_n = 1'b0;
        #1;
        exp_cnt[2] = 0;
        check("c_rst rdy", 64'(c_rdy), 64'd0);
        check("c_rst rv", 64'(c_rv), 64'd0);
        check("c_rst rdata", 64'(c_rdata), 64'd0);
        check("c_rst err", 64'(c_err), 64'd0);
        check("c_rst cnt", 64'(c_cnt), 64'(exp_cnt[2]));
        repeat (8) @(negedge clk);
        check("c_rst calls", 64'(rd_calls[2] + wr_calls[2] - r0), 64'd0);
        check("c_rst rv_late", 64'(c_rv), 64'd0);
        c_rst_n = 1'b1;
        #1;
        check("c_rel rdy", 64'(c_rdy), 64'd1);
        repeat (6) @(negedge clk);
        check("c_rel rv", 64'(c_rv), 64'd0);
        check("c_rel cnt", 64'(c_cnt), 64'(exp_cnt[2]));
        check("c_rel calls", 64'(rd_calls[2] + wr_calls[2] - r0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpi_mem_port.md
DPI_MEM_PORT -- requirements
Module: dpi_mem_port

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data path width; SHALL be 32 or 64.
REQ-002 Parameter LATENCY, default 1, extra wait cycles before access; SHALL be in range 0..15.
REQ-003 Derived NBYTES = DATA_WIDTH/8; LG = log2(NBYTES).
REQ-004 Port clock, input, 1: single clock; all state changes on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset (0 = in reset).
REQ-006 Port req_valid, input, 1: request present.
REQ-007 Port req_ready, output, 1: block can accept a request.
REQ-008 Port req_we, input, 1: 1 = write, 0 = read.
REQ-009 Port req_addr, input, 32: byte address.
REQ-010 Port req_wdata, input, DATA_WIDTH: write data.
REQ-011 Port req_wmask, input, NBYTES: byte write enables.
REQ-012 Port resp_valid, output, 1: response present.
REQ-013 Port resp_ready, input, 1: consumer accepts response.
REQ-014 Port resp_rdata, output, DATA_WIDTH: read data.
REQ-015 Port resp_err, output, 1: misaligned request flag.
REQ-016 Port txn_count, output, 32: completed-transaction counter.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-019 On accept: latch we/addr/wdata/wmask; load wait counter with LATENCY; enter WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; the access is performed on the edge where the counter is 0, with entry to RESP on the same edge.
REQ-021 Latency: accepted at edge E, resp_valid SHALL rise after edge E+1+LATENCY.
REQ-022 Each accepted request SHALL invoke the memory access (pmem_read / pmem_write) exactly once per 32-bit word, on one edge only.
REQ-023 For DATA_WIDTH=64, lower word uses addr, upper word uses addr+4; wmask[3:0] applies to lower, wmask[7:4] to upper.
REQ-024 Read data SHALL be sampled before any write in the same access, so on a write resp_rdata returns prior memory contents.
REQ-025 A write word whose 4-bit mask slice is 0 SHALL skip that pmem_write call; the pmem_read still occurs.
REQ-026 Misaligned request (addr[LG-1:0] != 0): no memory call; resp_rdata = 0; resp_err = 1.
REQ-027 Aligned request: resp_err = 0.
REQ-028 In RESP, resp_valid = 1 and resp_rdata/resp_err SHALL stay stable until resp_valid && resp_ready, then the FSM enters IDLE.
REQ-029 Back-to-back traffic: a new request is accepted no earlier than the cycle after the response handshake (one idle cycle minimum).
REQ-030 txn_count SHALL increment by 1 on each response handshake, erroneous ones included, wrapping 0xFFFFFFFF -> 0.
REQ-031 req_* inputs are don't-care outside the accept edge; later changes SHALL NOT affect an in-flight transaction.

Reset
REQ-032 reset=0 SHALL asynchronously force: state IDLE, req_ready 1 (once released), resp_valid 0, resp_rdata 0, resp_err 0, txn_count 0, wait counter 0.
REQ-033 While reset=0, req_ready SHALL be 0 and no memory call SHALL occur.
REQ-034 Reset during WAIT or RESP SHALL drop the transaction: no memory call after reset assertion, no response, and no txn_count increment.

Verification
REQ-035 LATENCY=1, DW=32: read addr 0x80000000 (mem=0x12345678), resp_ready=1 -> resp_valid rises 2 edges after accept, rdata 0x12345678, err 0, txn_count 1.
REQ-036 DW=32: write 0x80000004 data 0xAABBCCDD mask 0b0011 over 0x11223344 -> resp_rdata 0x11223344; memory afterwards 0x1122CCDD.
REQ-037 DW=64, LATENCY=0: read 0x80000008 -> exactly two pmem_read calls (0x80000008, 0x8000000C) on the same edge; resp 1 edge after accept.
REQ-038 DW=64: request addr 0x80000004 -> resp_err 1, rdata 0, zero memory calls, txn_count increments.
REQ-039 Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready 0; one cycle after the handshake req_ready=1.
REQ-040 Assert reset=0 in WAIT (LATENCY=3) -> outputs at reset values immediately, no memory call, txn_count 0.
